// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
interface mem_access_stage_if #(
  parameter int XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: loads/stores over a req/ack bus, registered MW_ writeback bundle.
// Optional bus timeout is enabled by defining BUS_TIMEOUT_EN.
module mem_access_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EM_valid,
  input  logic [XLEN-1:0]     EM_Result,
  input  logic [XLEN-1:0]     EM_store_data,
  input  logic                EM_mem_read,
  input  logic                EM_mem_write,
  input  logic [1:0]          EM_size,
  input  logic                EM_unsigned,
  input  logic [4:0]          EM_rd,
  input  logic                EM_reg_write,
  output logic                EM_ready,
  mem_access_stage_if.master  dmem,
  output logic                MW_valid,
  output logic [XLEN-1:0]     MW_data,
  output logic [4:0]          MW_rd,
  output logic                MW_reg_write,
  output logic                MW_misaligned,
  output logic                MW_bus_error
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t state_r, state_nxt_s;

  logic            req_r, req_nxt_s;
  logic            we_r, we_nxt_s;
  logic [XLEN-1:0] addr_r, addr_nxt_s;
  logic [XLEN-1:0] wdata_r, wdata_nxt_s;
  logic [3:0]      be_r, be_nxt_s;

  logic            mw_valid_r, mw_valid_nxt_s;
  logic [XLEN-1:0] mw_data_r, mw_data_nxt_s;
  logic [4:0]      mw_rd_r, mw_rd_nxt_s;
  logic            mw_rw_r, mw_rw_nxt_s;
  logic            mw_mis_r, mw_mis_nxt_s;
  logic            mw_berr_r, mw_berr_nxt_s;

  // Context of the outstanding transaction, needed when the ack returns
  logic            ld_r, ld_nxt_s;
  logic [1:0]      ld_off_r, ld_off_nxt_s;
  logic [1:0]      ld_size_r, ld_size_nxt_s;
  logic            ld_uns_r, ld_uns_nxt_s;
  logic [4:0]      ctx_rd_r, ctx_rd_nxt_s;
  logic            ctx_rw_r, ctx_rw_nxt_s;

  logic accept_s;
  logic is_mem_s;
  logic is_load_s;
  logic misaligned_s;
  logic timeout_s;

  function automatic logic [XLEN-1:0] load_select(input logic [XLEN-1:0] rdata,
                                                  input logic [1:0] off,
                                                  input logic [1:0] size,
                                                  input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_select = uns ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
      2'b01:   load_select = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
      default: load_select = rdata;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << {off[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] size, input logic [XLEN-1:0] sd);
    case (size)
      2'b00:   store_wdata = {(XLEN/8){sd[7:0]}};
      2'b01:   store_wdata = {(XLEN/16){sd[15:0]}};
      default: store_wdata = sd;
    endcase
  endfunction

  assign EM_ready  = (state_r == S_IDLE) && !rst;
  assign accept_s  = EM_valid && EM_ready;
  assign is_mem_s  = EM_mem_write || EM_mem_read;
  assign is_load_s = EM_mem_read && !EM_mem_write;

  // Alignment check on the effective address
  always_comb begin
    misaligned_s = 1'b0;
    case (EM_size)
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = EM_Result[0];
      default: misaligned_s = |EM_Result[1:0];
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_r;

  // Counts WAIT cycles without ack; cleared while idle so it restarts on every WAIT entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == S_IDLE) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (!dmem.dmem_ack) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_s = (state_r == S_WAIT) && !dmem.dmem_ack &&
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // A zero-cycle timeout is meaningless; nothing to build for sane values
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && is_mem_s && !misaligned_s) begin
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem.dmem_ack || timeout_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output/next-value logic; exception flags and MW_valid are single-cycle
  always_comb begin
    req_nxt_s      = req_r;
    we_nxt_s       = we_r;
    addr_nxt_s     = addr_r;
    wdata_nxt_s    = wdata_r;
    be_nxt_s       = be_r;
    mw_valid_nxt_s = 1'b0;
    mw_data_nxt_s  = mw_data_r;
    mw_rd_nxt_s    = mw_rd_r;
    mw_rw_nxt_s    = mw_rw_r;
    mw_mis_nxt_s   = 1'b0;
    mw_berr_nxt_s  = 1'b0;
    ld_nxt_s       = ld_r;
    ld_off_nxt_s   = ld_off_r;
    ld_size_nxt_s  = ld_size_r;
    ld_uns_nxt_s   = ld_uns_r;
    ctx_rd_nxt_s   = ctx_rd_r;
    ctx_rw_nxt_s   = ctx_rw_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && !is_mem_s) begin
          mw_valid_nxt_s = 1'b1;
          mw_data_nxt_s  = EM_Result;
          mw_rd_nxt_s    = EM_rd;
          mw_rw_nxt_s    = EM_reg_write;
        end else if (accept_s && misaligned_s) begin
          mw_valid_nxt_s = 1'b1;
          mw_data_nxt_s  = EM_Result;
          mw_rd_nxt_s    = EM_rd;
          mw_rw_nxt_s    = 1'b0;
          mw_mis_nxt_s   = 1'b1;
        end else if (accept_s) begin
          req_nxt_s     = 1'b1;
          we_nxt_s      = EM_mem_write;
          addr_nxt_s    = {EM_Result[XLEN-1:2], 2'b00};
          be_nxt_s      = is_load_s ? 4'b1111 : store_be(EM_size, EM_Result[1:0]);
          wdata_nxt_s   = is_load_s ? {XLEN{1'b0}} : store_wdata(EM_size, EM_store_data);
          ld_nxt_s      = is_load_s;
          ld_off_nxt_s  = EM_Result[1:0];
          ld_size_nxt_s = EM_size;
          ld_uns_nxt_s  = EM_unsigned;
          ctx_rd_nxt_s  = EM_rd;
          ctx_rw_nxt_s  = EM_reg_write;
        end else begin
          req_nxt_s = 1'b0;
        end
      end
      S_WAIT: begin
        if (dmem.dmem_ack) begin
          req_nxt_s      = 1'b0;
          mw_valid_nxt_s = 1'b1;
          mw_rd_nxt_s    = ctx_rd_r;
          mw_data_nxt_s  = ld_r ? load_select(dmem.dmem_rdata, ld_off_r, ld_size_r, ld_uns_r)
                                : {XLEN{1'b0}};
          mw_rw_nxt_s    = ld_r ? ctx_rw_r : 1'b0;
        end else if (timeout_s) begin
          req_nxt_s      = 1'b0;
          mw_valid_nxt_s = 1'b1;
          mw_rd_nxt_s    = ctx_rd_r;
          mw_data_nxt_s  = {XLEN{1'b0}};
          mw_rw_nxt_s    = 1'b0;
          mw_berr_nxt_s  = 1'b1;
        end else begin
          req_nxt_s = 1'b1;
        end
      end
      default: req_nxt_s = 1'b0;
    endcase
  end

  // Output and transaction-context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= {XLEN{1'b0}};
      wdata_r    <= {XLEN{1'b0}};
      be_r       <= 4'b0000;
      mw_valid_r <= 1'b0;
      mw_data_r  <= {XLEN{1'b0}};
      mw_rd_r    <= 5'd0;
      mw_rw_r    <= 1'b0;
      mw_mis_r   <= 1'b0;
      mw_berr_r  <= 1'b0;
      ld_r       <= 1'b0;
      ld_off_r   <= 2'b00;
      ld_size_r  <= 2'b00;
      ld_uns_r   <= 1'b0;
      ctx_rd_r   <= 5'd0;
      ctx_rw_r   <= 1'b0;
    end else begin
      req_r      <= req_nxt_s;
      we_r       <= we_nxt_s;
      addr_r     <= addr_nxt_s;
      wdata_r    <= wdata_nxt_s;
      be_r       <= be_nxt_s;
      mw_valid_r <= mw_valid_nxt_s;
      mw_data_r  <= mw_data_nxt_s;
      mw_rd_r    <= mw_rd_nxt_s;
      mw_rw_r    <= mw_rw_nxt_s;
      mw_mis_r   <= mw_mis_nxt_s;
      mw_berr_r  <= mw_berr_nxt_s;
      ld_r       <= ld_nxt_s;
      ld_off_r   <= ld_off_nxt_s;
      ld_size_r  <= ld_size_nxt_s;
      ld_uns_r   <= ld_uns_nxt_s;
      ctx_rd_r   <= ctx_rd_nxt_s;
      ctx_rw_r   <= ctx_rw_nxt_s;
    end
  end

  assign dmem.dmem_req   = req_r;
  assign dmem.dmem_we    = we_r;
  assign dmem.dmem_addr  = addr_r;
  assign dmem.dmem_wdata = wdata_r;
  assign dmem.dmem_be    = be_r;
  assign MW_valid        = mw_valid_r;
  assign MW_data         = mw_data_r;
  assign MW_rd           = mw_rd_r;
  assign MW_reg_write    = mw_rw_r;
  assign MW_misaligned   = mw_mis_r;
  assign MW_bus_error    = mw_berr_r;

endmodule
